// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: stream field widths,
// address step and the loader FSM state encoding.
package imem_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int ADDR_STEP  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    function automatic logic state_takes_bytes(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Little-endian 4-byte shift register; full flags the byte that completes a word
// so the loader can capture word_next on the same edge.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              full
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] word_q,  word_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        word_next = {byte_in, word_q[WORD_W-1:BYTE_W]};
        full      = byte_en && (count_q == CNT_W'(WORD_BYTES - 1));
        word_d    = word_q;
        count_d   = count_q;
        if (clr) begin
            word_d  = '0;
            count_d = '0;
        end else if (byte_en) begin
            word_d  = word_next;
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// through the core debug port, holding the core in reset until the load checks out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              XLEN               = 64,
    parameter int              INSTRUCTION_LENGTH = XLEN / 2,
    parameter logic [XLEN-1:0] BASE_ADDR          = '0,
    parameter int              LEN_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          byte_valid,
    input  logic [BYTE_W-1:0]             byte_data,
    output logic                          byte_ready,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          core_rst,
    output logic                          done,
    output logic                          error
);

    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]          cnt_q,       cnt_d;
    logic [XLEN-1:0]               addr_q,      addr_d;
    logic [XLEN-1:0]               dbg_addr_q,  dbg_addr_d;
    logic [INSTRUCTION_LENGTH-1:0] dbg_instr_q, dbg_instr_d;
    logic                          dbg_wr_en_q, dbg_wr_en_d;
    logic [BYTE_W-1:0]             csum_q,      csum_d;
    logic                          done_q,      done_d;
    logic                          error_q,     error_d;
    logic                          core_rst_q,  core_rst_d;

    logic                 accept;
    logic                 session_start;
    logic                 pk_clr;
    logic                 pk_en;
    logic                 pk_full;
    logic [WORD_W-1:0]    pk_word_next;
    logic [LEN_WIDTH-1:0] len_full;

    assign accept        = byte_valid && byte_ready;
    assign session_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign pk_en         = accept && (state_q == ST_DATA);
    assign pk_clr        = session_start;
    assign len_full      = LEN_WIDTH'({byte_data, cnt_q[BYTE_W-1:0]});

    byte_to_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .byte_en   (pk_en),
        .byte_in   (byte_data),
        .word_next (pk_word_next),
        .full      (pk_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (session_start) state_d = ST_LEN_LO;
            ST_LEN_LO:        if (accept) state_d = ST_LEN_HI;
            ST_LEN_HI:        if (accept) state_d = (len_full == '0) ? ST_CHECK : ST_DATA;
            ST_DATA:          if (pk_full) state_d = ST_WRITE;
            ST_WRITE:         state_d = (cnt_q == LEN_WIDTH'(1)) ? ST_CHECK : ST_DATA;
            ST_CHECK:         if (accept) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = state_takes_bytes(state_q);
        dbg_wr_en  = dbg_wr_en_q;
        dbg_addr   = dbg_addr_q;
        dbg_instr  = dbg_instr_q;
        core_rst   = core_rst_q;
        done       = done_q;
        error      = error_q;
    end

    // The write strobe, address and word are captured together as the 4th byte lands,
    // so all three are registered and line up exactly with the WRITE state.
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_instr_d = dbg_instr_q;
        dbg_wr_en_d = 1'b0;
        csum_d      = csum_q;
        done_d      = done_q;
        error_d     = error_q;
        core_rst_d  = core_rst_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (session_start) begin
                    cnt_d      = '0;
                    addr_d     = BASE_ADDR;
                    csum_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    core_rst_d = 1'b1;
                end
            end
            ST_LEN_LO: if (accept) cnt_d = LEN_WIDTH'(byte_data);
            ST_LEN_HI: if (accept) cnt_d = len_full;
            ST_DATA: begin
                if (accept) csum_d = csum_q ^ byte_data;
                if (pk_full) begin
                    dbg_wr_en_d = 1'b1;
                    dbg_addr_d  = addr_q;
                    dbg_instr_d = INSTRUCTION_LENGTH'(pk_word_next);
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + XLEN'(ADDR_STEP);
                cnt_d  = cnt_q - 1'b1;
            end
            ST_CHECK: begin
                if (accept) begin
                    if (byte_data == csum_q) begin
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            addr_q      <= BASE_ADDR;
            dbg_addr_q  <= BASE_ADDR;
            dbg_instr_q <= '0;
            dbg_wr_en_q <= 1'b0;
            csum_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            core_rst_q  <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_instr_q <= dbg_instr_d;
            dbg_wr_en_q <= dbg_wr_en_d;
            csum_q      <= csum_d;
            done_q      <= done_d;
            error_q     <= error_d;
            core_rst_q  <= core_rst_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good, bad and empty loads,
// stalled handshakes, mid-session reset and start filtering.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        dbg_wr_en;
    logic [63:0] dbg_addr;
    logic [31:0] dbg_instr;
    logic        core_rst;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_instr[$];
    int          ready_in_write = 0;
    int          max_run = 0;
    int          run = 0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .dbg_wr_en  (dbg_wr_en),
        .dbg_addr   (dbg_addr),
        .dbg_instr  (dbg_instr),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobed write and its pulse length.
    always @(negedge clk) begin
        if (dbg_wr_en) begin
            wr_addr.push_back(dbg_addr);
            wr_instr.push_back(dbg_instr);
            run = run + 1;
            if (run > max_run) max_run = run;
            if (byte_ready) ready_in_write = ready_in_write + 1;
        end else begin
            run = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 0;
        int t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                if (byte_ready) ok = 1;
            end
            t++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_handshake: byte %h not accepted, got byte_ready=%b want 1 within 200 cycles", b, byte_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic end_stream();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish();
        int t = 0;
        while (!(done || error) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!(done || error)) begin
            errors++;
            $display("FAIL finish_timeout: got done=%b error=%b want one of them high", done, error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_rst, byte_ready, dbg_wr_en, done, error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got core_rst,ready,wr,done,err=%b want 10000",
                     {core_rst, byte_ready, dbg_wr_en, done, error});
        end
        checks++;
        if (dbg_addr !== 64'h0 || dbg_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_dbg: got addr=%h instr=%h want 0 and 0", dbg_addr, dbg_instr);
        end
    endtask

    // Data bytes 13 00 00 00 93 00 10 00 XOR to 0x90.
    task automatic test_good_load();
        int base = wr_addr.size();
        pulse_start();
        checks++;
        if (core_rst !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL good_len_lo: got core_rst=%b byte_ready=%b want 1 1", core_rst, byte_ready);
        end
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        send_byte(8'h90, 0);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() - base != 2) begin
            errors++;
            $display("FAIL good_write_count: got %0d want 2", wr_addr.size() - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 64'h0 || wr_instr[base] !== 32'h0000_0013) begin
                errors++;
                $display("FAIL good_write0: got %h/%h want 0/00000013", wr_addr[base], wr_instr[base]);
            end
            checks++;
            if (wr_addr[base+1] !== 64'h4 || wr_instr[base+1] !== 32'h0010_0093) begin
                errors++;
                $display("FAIL good_write1: got %h/%h want 4/00100093", wr_addr[base+1], wr_instr[base+1]);
            end
        end
        checks++;
        if ({done, error, core_rst, byte_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL good_status: got done,err,core_rst,ready=%b want 1000", {done, error, core_rst, byte_ready});
        end
    endtask

    task automatic test_bad_checksum();
        int base = wr_addr.size();
        pulse_start();
        checks++;
        if (done !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: got done=%b core_rst=%b want 0 1", done, core_rst);
        end
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        send_byte(8'h81, 0);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() - base != 2) begin
            errors++;
            $display("FAIL bad_write_count: got %0d want 2", wr_addr.size() - base);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({done, error, core_rst} !== 3'b011) begin
            errors++;
            $display("FAIL bad_status_hold: got done,err,core_rst=%b want 011", {done, error, core_rst});
        end
    endtask

    task automatic test_empty_load();
        int base = wr_addr.size();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() != base) begin
            errors++;
            $display("FAIL empty_no_write: got %0d writes want 0", wr_addr.size() - base);
        end
        checks++;
        if ({done, error, core_rst} !== 3'b100) begin
            errors++;
            $display("FAIL empty_status: got done,err,core_rst=%b want 100", {done, error, core_rst});
        end
    endtask

    // Third word DEADBEEF brings the checksum to 0x90 ^ 0x22 = 0xB2.
    task automatic test_stall();
        int base = wr_addr.size();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h0000_0013; exp_w[1] = 32'h0010_0093; exp_w[2] = 32'hDEAD_BEEF;
        pulse_start();
        send_byte(8'h03, 1); send_byte(8'h00, 1);
        for (int i = 0; i < 3; i++) send_word(exp_w[i], 1);
        send_byte(8'hB2, 1);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() - base != 3) begin
            errors++;
            $display("FAIL stall_write_count: got %0d want 3", wr_addr.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[base+i] !== 64'(4 * i) || wr_instr[base+i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL stall_write%0d: got %h/%h want %h/%h", i, wr_addr[base+i], wr_instr[base+i],
                             64'(4 * i), exp_w[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL stall_status: got done=%b error=%b want 1 0", done, error);
        end
    endtask

    // Clean load 12345678: checksum 78^56^34^12 = 0x08.
    task automatic test_abort();
        int base = wr_addr.size();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({core_rst, byte_ready, dbg_wr_en, done, error} !== 5'b10000) begin
            errors++;
            $display("FAIL abort_flags: got core_rst,ready,wr,done,err=%b want 10000",
                     {core_rst, byte_ready, dbg_wr_en, done, error});
        end
        checks++;
        if (dbg_addr !== 64'h0 || dbg_instr !== 32'h0) begin
            errors++;
            $display("FAIL abort_dbg: got addr=%h instr=%h want 0 and 0", dbg_addr, dbg_instr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != base) begin
            errors++;
            $display("FAIL abort_no_write: got %0d writes want 0", wr_addr.size() - base);
        end
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'h1234_5678, 0);
        send_byte(8'h08, 0);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() - base != 1 || wr_addr[base] !== 64'h0 || wr_instr[base] !== 32'h1234_5678 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_reload: got writes=%0d done=%b want 1 write 0/12345678 done=1",
                     wr_addr.size() - base, done);
        end
    endtask

    // Restart word AABBCCDD: checksum DD^CC^BB^AA = 0x00.
    task automatic test_start_ignored();
        int base = wr_addr.size();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0);
        end_stream();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() - base != 1 || wr_addr[base] !== 64'h0 || wr_instr[base] !== 32'h0000_0013) begin
            errors++;
            $display("FAIL start_in_data: got writes=%0d want 1 write 0/00000013", wr_addr.size() - base);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL start_in_data_status: got done=%b error=%b want 1 0", done, error);
        end
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'h00, 0);
        end_stream();
        wait_finish();
        checks++;
        if (wr_addr.size() - base != 1 || wr_addr[base] !== 64'h0 || wr_instr[base] !== 32'hAABB_CCDD || done !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_done: got writes=%0d done=%b want 1 write 0/aabbccdd done=1",
                     wr_addr.size() - base, done);
        end
    endtask

    task automatic test_write_strobe();
        checks++;
        if (max_run !== 1) begin
            errors++;
            $display("FAIL wr_en_width: got longest pulse %0d cycles want 1", max_run);
        end
        checks++;
        if (ready_in_write !== 0) begin
            errors++;
            $display("FAIL ready_in_write: got %0d cycles with byte_ready=1 during write want 0", ready_in_write);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_empty_load();
        test_stall();
        test_abort();
        test_start_ignored();
        test_write_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
